// File: rtl/serial_pattern_pkg.sv
// rtl/serial_pattern_pkg.sv - shared types and detector step function for the serial pattern transmitter
package serial_pattern_pkg;

  // Transmitter phases: waiting for a word, shifting it out, forced idle between words
  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_SEND = 2'd1,
    TX_GAP  = 2'd2
  } tx_state_t;

  // Detector states for the "110"/"101" sequence detector
  typedef enum logic [1:0] {
    D0 = 2'd0,
    D1 = 2'd1,
    D2 = 2'd2,
    D3 = 2'd3
  } det_state_t;

  typedef struct packed {
    det_state_t next;
    logic       z;
  } det_step_t;

  // One detector step: D2 flags a "110" on a 0, D3 flags a "101" on a 1
  function automatic det_step_t step(input det_state_t state, input logic x);
    det_step_t r;
    r.next = D0;
    r.z    = 1'b0;
    case (state)
      D0: r.next = x ? D1 : D0;
      D1: r.next = x ? D2 : D3;
      D2: begin
        r.next = x ? D2 : D0;
        r.z    = ~x;
      end
      D3: begin
        r.next = D0;
        r.z    = x;
      end
      default: r.next = D0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seq_det_model.sv
// rtl/seq_det_model.sv - cycle-accurate reference model of the sequence detector
module seq_det_model
  import serial_pattern_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic x,
  output logic exp_z
);

  det_state_t state;
  det_step_t  nxt;

  // Next state and z for the bit currently on the line
  always_comb begin
    nxt = step(state, x);
  end

  // Model state is only cleared by reset, so patterns may span word boundaries
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= D0;
      exp_z <= 1'b0;
    end else begin
      state <= nxt.next;
      exp_z <= nxt.z;
    end
  end

endmodule

// File: rtl/serial_pattern_tx.sv
// rtl/serial_pattern_tx.sv - parallel-to-serial word transmitter with built-in detector reference
module serial_pattern_tx
  import serial_pattern_pkg::*;
#(
  parameter int   N        = 8,
  parameter int   GAP      = 2,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] data,
  input  logic         dav,
  output logic         rfd,
  output logic         x,
  output logic         busy,
  output logic         last,
  output logic         exp_z
);

  localparam int            CW      = $clog2(N);
  localparam logic [CW-1:0] CNT_MAX = CW'(N - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  tx_state_t     state, state_n;
  logic [N-1:0]  sr, sr_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          x_n, rfd_n, busy_n, last_n;
  logic          capture;
  logic          gap_load;
  logic          gap_done;

  // A word is taken on any edge where the producer offers it and we advertise ready
  assign capture = dav & rfd;

  // Next-state and registered-output decode; the shift register keeps the next bit at its MSB
  always_comb begin
    state_n  = state;
    sr_n     = sr;
    cnt_n    = cnt;
    x_n      = x;
    rfd_n    = rfd;
    busy_n   = busy;
    last_n   = last;
    gap_load = 1'b0;
    case (state)
      TX_IDLE: begin
        rfd_n = 1'b1;
        x_n   = IDLE_BIT;
        if (capture) begin
          sr_n    = {data[N-2:0], 1'b0};
          cnt_n   = CNT_MAX;
          x_n     = data[N-1];
          rfd_n   = 1'b0;
          busy_n  = 1'b1;
          last_n  = 1'b0;
          state_n = TX_SEND;
        end
      end
      TX_SEND: begin
        if (cnt != '0) begin
          x_n    = sr[N-1];
          sr_n   = {sr[N-2:0], 1'b0};
          cnt_n  = cnt - CNT_ONE;
          last_n = (cnt == CNT_ONE);
          // With no gap, ready is raised during the final bit so the next word follows directly
          rfd_n  = (GAP == 0) && (cnt == CNT_ONE);
        end else if (GAP > 0) begin
          x_n      = IDLE_BIT;
          busy_n   = 1'b0;
          last_n   = 1'b0;
          rfd_n    = 1'b0;
          gap_load = 1'b1;
          state_n  = TX_GAP;
        end else if (capture) begin
          sr_n    = {data[N-2:0], 1'b0};
          cnt_n   = CNT_MAX;
          x_n     = data[N-1];
          rfd_n   = 1'b0;
          busy_n  = 1'b1;
          last_n  = 1'b0;
          state_n = TX_SEND;
        end else begin
          x_n     = IDLE_BIT;
          busy_n  = 1'b0;
          last_n  = 1'b0;
          state_n = TX_IDLE;
        end
      end
      TX_GAP: begin
        x_n = IDLE_BIT;
        if (gap_done) begin
          rfd_n   = 1'b1;
          state_n = TX_IDLE;
        end
      end
      default: begin
        x_n     = IDLE_BIT;
        state_n = TX_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any word in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= TX_IDLE;
      sr    <= '0;
      cnt   <= '0;
      x     <= IDLE_BIT;
      rfd   <= 1'b0;
      busy  <= 1'b0;
      last  <= 1'b0;
    end else begin
      state <= state_n;
      sr    <= sr_n;
      cnt   <= cnt_n;
      x     <= x_n;
      rfd   <= rfd_n;
      busy  <= busy_n;
      last  <= last_n;
    end
  end

  if (GAP > 0) begin : g_gap
    localparam int            GW        = $clog2(GAP + 1);
    localparam logic [GW-1:0] GCNT_INIT = GW'(GAP - 1);
    localparam logic [GW-1:0] GCNT_ONE  = GW'(1);

    logic [GW-1:0] gcnt;

    // Counts the remaining idle bit-times between words
    always_ff @(posedge clock) begin
      if (reset) begin
        gcnt <= '0;
      end else if (gap_load) begin
        gcnt <= GCNT_INIT;
      end else if ((state == TX_GAP) && (gcnt != '0)) begin
        gcnt <= gcnt - GCNT_ONE;
      end
    end

    assign gap_done = (gcnt == '0);
  end else begin : g_no_gap
    logic unused_gap_load;
    assign unused_gap_load = gap_load;
    assign gap_done        = 1'b1;
  end

  seq_det_model u_det (
    .clock (clock),
    .reset (reset),
    .x     (x),
    .exp_z (exp_z)
  );

endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb/tb_serial_pattern_tx.sv - self-checking bench for serial_pattern_tx
module tb_serial_pattern_tx;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] data0, data1;
  logic [3:0] data2;
  logic [2:0] dav, rfd, x, busy, last, exp_z;

  int checks = 0;
  int errors = 0;

  // Instance 0: N=8 GAP=2, instance 1: N=8 GAP=0, instance 2: N=4 GAP=2
  int         pos      [3];
  logic [7:0] word     [3];
  bit         rst_seen [3];
  int         det      [3];
  bit         ez       [3];
  int         cap_cnt  [3];
  int         zcnt     [3];
  bit         chk_on = 1'b0;

  int nx_tab [4][2] = '{'{0, 1}, '{3, 2}, '{0, 2}, '{0, 0}};
  int z_tab  [4][2] = '{'{0, 0}, '{0, 0}, '{1, 0}, '{0, 1}};

  always #5 clock = ~clock;

  serial_pattern_tx #(.N(8), .GAP(2), .IDLE_BIT(1'b0)) dut0 (
    .clock(clock), .reset(reset), .data(data0), .dav(dav[0]), .rfd(rfd[0]),
    .x(x[0]), .busy(busy[0]), .last(last[0]), .exp_z(exp_z[0]));

  serial_pattern_tx #(.N(8), .GAP(0), .IDLE_BIT(1'b0)) dut1 (
    .clock(clock), .reset(reset), .data(data1), .dav(dav[1]), .rfd(rfd[1]),
    .x(x[1]), .busy(busy[1]), .last(last[1]), .exp_z(exp_z[1]));

  serial_pattern_tx #(.N(4), .GAP(2), .IDLE_BIT(1'b0)) dut2 (
    .clock(clock), .reset(reset), .data(data2), .dav(dav[2]), .rfd(rfd[2]),
    .x(x[2]), .busy(busy[2]), .last(last[2]), .exp_z(exp_z[2]));

  function automatic int n_of(input int i);
    return (i == 2) ? 4 : 8;
  endfunction

  function automatic int gap_of(input int i);
    return (i == 1) ? 0 : 2;
  endfunction

  // pos counts bit-times since capture: 1..N carry bits, N+1..N+GAP are gap cycles, 0 is idle
  function automatic logic ex_x(input int i);
    if (pos[i] >= 1 && pos[i] <= n_of(i)) return word[i][n_of(i) - pos[i]];
    return 1'b0;
  endfunction

  function automatic logic ex_rfd(input int i);
    if (pos[i] == 0) return !rst_seen[i];
    if (pos[i] == n_of(i)) return gap_of(i) == 0;
    return 1'b0;
  endfunction

  function automatic logic ex_busy(input int i);
    return pos[i] >= 1 && pos[i] <= n_of(i);
  endfunction

  function automatic logic ex_last(input int i);
    return pos[i] == n_of(i);
  endfunction

  function automatic logic [7:0] din(input int i);
    case (i)
      0: return data0;
      1: return data1;
      default: return {4'h0, data2};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference model advances on every edge using the inputs the DUT sees
  always @(posedge clock) begin
    for (int i = 0; i < 3; i++) begin
      logic cx, crfd;
      cx   = ex_x(i);
      crfd = ex_rfd(i);
      if (reset) begin
        pos[i]      = 0;
        rst_seen[i] = 1'b1;
        det[i]      = 0;
        ez[i]       = 1'b0;
      end else begin
        ez[i]  = z_tab[det[i]][cx] != 0;
        det[i] = nx_tab[det[i]][cx];
        if (dav[i] && crfd) begin
          word[i] = din(i);
          pos[i]  = 1;
          cap_cnt[i]++;
        end else if (pos[i] > 0) begin
          pos[i]++;
          if (pos[i] > n_of(i) + gap_of(i)) pos[i] = 0;
        end
        rst_seen[i] = 1'b0;
      end
    end
    if (reset) chk_on = 1'b1;
  end

  // Every output of every instance is compared to the model away from the active edge
  always @(negedge clock) begin
    if (chk_on) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("x%0d", i), x[i], ex_x(i));
        check($sformatf("rfd%0d", i), rfd[i], ex_rfd(i));
        check($sformatf("busy%0d", i), busy[i], ex_busy(i));
        check($sformatf("last%0d", i), last[i], ex_last(i));
        check($sformatf("exp_z%0d", i), exp_z[i], ez[i]);
        if (exp_z[i] === 1'b1) zcnt[i]++;
      end
    end
  end

  task automatic set_data(input int i, input logic [7:0] w);
    case (i)
      0: data0 = w;
      1: data1 = w;
      default: data2 = w[3:0];
    endcase
  endtask

  task automatic send(input int i, input logic [7:0] w, input bit keep);
    int c0, n;
    c0 = cap_cnt[i];
    n  = 0;
    set_data(i, w);
    dav[i] = 1'b1;
    while (cap_cnt[i] == c0 && n < 64) begin
      @(posedge clock);
      #1;
      n++;
    end
    check($sformatf("captured%0d", i), cap_cnt[i] - c0, 1);
    if (!keep) dav[i] = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    int z0, n, b;
    logic [15:0] sig;
    reset = 1'b1;
    dav   = '0;
    data0 = '0;
    data1 = '0;
    data2 = '0;

    // Reset for three edges, then release
    wait_cycles(3);
    check("rst_x", x, 3'b000);
    check("rst_rfd", rfd, 3'b000);
    check("rst_busy", busy, 3'b000);
    check("rst_exp_z", exp_z, 3'b000);
    reset = 1'b0;
    wait_cycles(1);
    check("rfd_after_release", rfd, 3'b111);

    // Single word 0x35 with a two-cycle gap
    z0 = zcnt[0];
    send(0, 8'h35, 1'b0);
    sig = '0;
    for (int k = 0; k < 8; k++) begin
      sig = {sig[14:0], x[0]};
      wait_cycles(1);
    end
    check("t2_bits", sig[7:0], 8'h35);
    check("t2_rfd_in_gap", rfd[0], 1'b0);
    wait_cycles(2);
    check("t2_rfd_back", rfd[0], 1'b1);
    check("t2_zpulses", zcnt[0] - z0, 2);

    // Second word offered immediately with dav held: only taken after the gap
    send(0, 8'h35, 1'b1);
    data0 = 8'hA5;
    n = 0;
    while (rfd[0] !== 1'b1 && n < 50) begin
      wait_cycles(1);
      n++;
    end
    check("t3_rfd_wait", n, 10);
    wait_cycles(1);
    dav[0] = 1'b0;
    check("t3_first_bit", x[0], 1'b1);
    check("t3_busy", busy[0], 1'b1);
    wait_cycles(12);

    // GAP=0: 0xFF then 0x00 back to back
    z0 = zcnt[1];
    send(1, 8'hFF, 1'b1);
    data1 = 8'h00;
    sig = '0;
    b = 0;
    for (int k = 0; k < 16; k++) begin
      sig = {sig[14:0], x[1]};
      if (busy[1] === 1'b1) b++;
      if (k == 0) dav[1] = 1'b1;
      if (k == 8) dav[1] = 1'b0;
      wait_cycles(1);
    end
    check("t4_bits", sig, 16'hFF00);
    check("t4_busy_run", b, 16);
    wait_cycles(3);
    check("t4_zpulses", zcnt[1] - z0, 1);

    // Reset on the edge after bit 4 of 0xDB aborts the word
    send(0, 8'hDB, 1'b0);
    wait_cycles(3);
    reset = 1'b1;
    wait_cycles(1);
    reset = 1'b0;
    check("t5_x", x[0], 1'b0);
    check("t5_busy", busy[0], 1'b0);
    check("t5_exp_z", exp_z[0], 1'b0);
    b = 0;
    for (int k = 0; k < 12; k++) begin
      if (busy[0] === 1'b1 || x[0] === 1'b1) b++;
      wait_cycles(1);
    end
    check("t5_no_more_bits", b, 0);
    send(0, 8'h6C, 1'b0);
    wait_cycles(12);

    // N=4 word 1011
    z0 = zcnt[2];
    send(2, 8'h0B, 1'b0);
    sig = '0;
    for (int k = 0; k < 4; k++) begin
      sig = {sig[14:0], x[2]};
      wait_cycles(1);
    end
    check("t6_bits", sig[3:0], 4'hB);
    wait_cycles(3);
    check("t6_zpulses", zcnt[2] - z0, 1);

    // Randomized words, spacing and occasional mid-word resets, all checked by the model
    for (int k = 0; k < 60; k++) begin
      int i;
      logic [7:0] w;
      i = $urandom_range(0, 2);
      w = 8'($urandom);
      send(i, w, 1'b0);
      if ($urandom_range(0, 9) == 0) begin
        wait_cycles($urandom_range(0, 6));
        reset = 1'b1;
        wait_cycles(1);
        reset = 1'b0;
      end else begin
        wait_cycles($urandom_range(0, 3));
      end
    end
    dav = '0;
    wait_cycles(25);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
